// File: rtl/md_rx_if.sv
// MD valid/ready bus between an MD master and an MD responder.
// The master drives the transfer and the responder answers with ready/err.
interface md_rx_if #(
    parameter int DATA_WIDTH = 32
);
    localparam int BYTES        = DATA_WIDTH / 8;
    localparam int OFFSET_WIDTH = ($clog2(BYTES) > 0) ? $clog2(BYTES) : 1;
    localparam int SIZE_WIDTH   = $clog2(BYTES) + 1;

    logic                    md_valid;
    logic [DATA_WIDTH-1:0]   md_data;
    logic [OFFSET_WIDTH-1:0] md_offset;
    logic [SIZE_WIDTH-1:0]   md_size;
    logic                    md_ready;
    logic                    md_err;

    modport master (
        output md_valid, md_data, md_offset, md_size,
        input  md_ready, md_err
    );

    modport slave (
        input  md_valid, md_data, md_offset, md_size,
        output md_ready, md_err
    );
endinterface

// File: rtl/md_rx_responder.sv
// MD responder: completes MD transfers with ready/err and queues the addressed
// bytes of each legal transfer in a first-word fall-through output FIFO.
// Optional wait states are enabled by defining MD_RSP_WAIT_STATES_EN.
//
// state | meaning
// IDLE  | waiting for md_valid; FIFO space is reserved here
// RESP  | md_ready (and md_err for illegal transfers) high for one cycle
// WAIT  | extra response delay, counted down from wait_cycles (macro only)
module md_rx_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    localparam int BYTES        = DATA_WIDTH / 8,
    localparam int OFFSET_WIDTH = ($clog2(BYTES) > 0) ? $clog2(BYTES) : 1,
    localparam int SIZE_WIDTH   = $clog2(BYTES) + 1,
    localparam int PTR_WIDTH    = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    md_rx_if.slave                md,
`ifdef MD_RSP_WAIT_STATES_EN
    input  logic [3:0]            wait_cycles,
`endif
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [SIZE_WIDTH-1:0] out_size,
    input  logic                  out_ready,
    output logic [PTR_WIDTH:0]    fifo_lvl
);

`ifdef MD_RSP_WAIT_STATES_EN
    typedef enum logic [1:0] {IDLE, RESP, WAIT} state_t;
    logic [3:0] cnt_q, cnt_d;
`else
    typedef enum logic [1:0] {IDLE, RESP} state_t;
`endif

    state_t state_q, state_d;
    logic   err_q, err_d;
    logic   ready_q, ready_d;
    logic   rsp_err_q, rsp_err_d;

    logic                  illegal;
    logic [SIZE_WIDTH:0]   span;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] extracted;

    logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
    logic [SIZE_WIDTH-1:0] size_mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr, rd_ptr;
    logic [PTR_WIDTH:0]    lvl;
    logic                  fifo_full, push, pop;

    // Legality check and byte extraction; the span is one bit wider than
    // md_size so offset+size can never wrap back into the legal range.
    always_comb begin
        span    = {1'b0, md.md_size}
                + {{(SIZE_WIDTH + 1 - OFFSET_WIDTH){1'b0}}, md.md_offset};
        illegal = (md.md_size == '0) || (span > (SIZE_WIDTH + 1)'(BYTES));
        shifted = md.md_data >> (8 * md.md_offset);
        for (int i = 0; i < BYTES; i++) begin
            extracted[8*i +: 8] = (i < int'(md.md_size)) ? shifted[8*i +: 8] : 8'h00;
        end
    end

    // Next-state logic; ready/err are derived from the next state so both
    // come straight out of flops.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
`ifdef MD_RSP_WAIT_STATES_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (md.md_valid && (illegal || !fifo_full)) begin
                    err_d = illegal;
`ifdef MD_RSP_WAIT_STATES_EN
                    if (wait_cycles != 4'd0) begin
                        state_d = WAIT;
                        cnt_d   = wait_cycles;
                    end else begin
                        state_d = RESP;
                    end
`else
                    state_d = RESP;
`endif
                end
            end
            RESP: state_d = IDLE;
`ifdef MD_RSP_WAIT_STATES_EN
            WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        ready_d   = (state_d == RESP);
        rsp_err_d = ready_d && err_d;
    end

    // FSM and response registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            err_q     <= 1'b0;
            ready_q   <= 1'b0;
            rsp_err_q <= 1'b0;
`ifdef MD_RSP_WAIT_STATES_EN
            cnt_q     <= 4'd0;
`endif
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            ready_q   <= ready_d;
            rsp_err_q <= rsp_err_d;
`ifdef MD_RSP_WAIT_STATES_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign md.md_ready = ready_q;
    assign md.md_err   = rsp_err_q;

    assign fifo_full = (lvl == (PTR_WIDTH + 1)'(FIFO_DEPTH));
    assign push      = ready_q && !rsp_err_q;
    assign pop       = out_valid && out_ready;

    // FIFO storage; contents need no reset because the level gates the outputs.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= extracted;
            size_mem[wr_ptr] <= md.md_size;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            lvl    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   lvl <= lvl + 1'b1;
                2'b01:   lvl <= lvl - 1'b1;
                default: lvl <= lvl;
            endcase
        end
    end

    assign out_valid = (lvl != '0);
    assign out_data  = out_valid ? data_mem[rd_ptr] : '0;
    assign out_size  = out_valid ? size_mem[rd_ptr] : '0;
    assign fifo_lvl  = lvl;

endmodule

// File: tb/tb_md_rx_responder.sv
// Bench for md_rx_responder (DATA_WIDTH=32, FIFO_DEPTH=4, default build).
module tb_md_rx_responder;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] data;
        int          size;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        out_valid;
    logic [31:0] out_data;
    logic [2:0]  out_size;
    logic        out_ready;
    logic [2:0]  fifo_lvl;

    md_rx_if #(.DATA_WIDTH(DW)) bus ();

    md_rx_responder #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .md        (bus),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_size  (out_size),
        .out_ready (out_ready),
        .fifo_lvl  (fifo_lvl)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    entry_t q[$];
    bit     exp_ready = 0;
    bit     exp_err   = 0;
    bit     completed = 0;
    bit     rand_pop  = 0;
    int     lat;

    function automatic bit is_illegal(int off, int sz);
        return (sz == 0) || (off + sz > DW / 8);
    endfunction

    function automatic logic [31:0] extract(logic [31:0] d, int off, int sz);
        logic [63:0] w;
        logic [63:0] m;
        w = {32'b0, d} >> (8 * off);
        m = (64'd1 << (8 * sz)) - 64'd1;
        return 32'(w & m);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every visible output against the reference state.
    task automatic check_outputs();
        chk("md_ready",  32'(bus.md_ready),  32'(exp_ready));
        chk("md_err",    32'(bus.md_err),    32'(exp_err));
        chk("fifo_lvl",  32'(fifo_lvl),      32'(q.size()));
        chk("out_valid", 32'(out_valid),     32'(q.size() > 0));
        chk("out_data",  out_data,           (q.size() > 0) ? q[0].data : 32'h0);
        chk("out_size",  32'(out_size),      (q.size() > 0) ? 32'(q[0].size) : 32'h0);
    endtask

    // One clock: predict from the rules what this edge does, then check.
    task automatic tick();
        bit ill, pop, push, acc, done;
        int off, sz;
        entry_t e;
        if (rand_pop) out_ready = 1'($urandom_range(0, 1));
        off  = int'(bus.md_offset);
        sz   = int'(bus.md_size);
        ill  = is_illegal(off, sz);
        pop  = out_ready && (q.size() > 0);
        done = exp_ready && bus.md_valid;
        push = done && !ill;
        acc  = !exp_ready && bus.md_valid && (ill || q.size() < DEPTH);
        e.data = extract(bus.md_data, off, sz);
        e.size = sz;
        @(posedge clk);
        #1;
        if (!reset_n) begin
            q.delete();
            exp_ready = 0;
            exp_err   = 0;
            completed = 0;
        end else begin
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(e);
            exp_ready = acc;
            exp_err   = acc && ill;
            completed = done;
        end
        check_outputs();
    endtask

    task automatic drive(input logic [31:0] d, input int off, input int sz);
        bus.md_valid  = 1'b1;
        bus.md_data   = d;
        bus.md_offset = 2'(off);
        bus.md_size   = 3'(sz);
    endtask

    // Hold a transfer until it completes; lat is the number of edges taken.
    task automatic xfer(input logic [31:0] d, input int off, input int sz, output int n);
        drive(d, off, sz);
        n = 0;
        completed = 0;
        while (!completed && n < 40) begin
            tick();
            n++;
        end
        chk("xfer_timeout", 32'(completed), 32'd1);
        bus.md_valid = 1'b0;
    endtask

    initial begin
        int n;
        bus.md_valid  = 1'b0;
        bus.md_data   = '0;
        bus.md_offset = '0;
        bus.md_size   = '0;
        out_ready     = 1'b0;
        reset_n       = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Legal transfer: two edges, bytes BB CC extracted.
        xfer(32'hAABBCCDD, 1, 2, lat);
        chk("legal_latency", 32'(lat), 32'd2);
        chk("legal_data", out_data, 32'h0000BBCC);
        chk("legal_size", 32'(out_size), 32'd2);

        // Illegal transfers: ready+err, nothing queued.
        drive(32'h11223344, 3, 2);
        tick();
        chk("ill_span_err", 32'(bus.md_err), 32'd1);
        tick();
        bus.md_valid = 1'b0;
        chk("ill_span_lvl", 32'(fifo_lvl), 32'd1);
        xfer(32'h55667788, 0, 0, lat);
        chk("ill_zero_latency", 32'(lat), 32'd2);
        tick();

        // Fill the FIFO, then a fifth transfer is held off until a pop.
        for (int i = 0; i < 3; i++) begin
            xfer($urandom, i, 1 + i % 2, lat);
            tick();
        end
        chk("full_lvl", 32'(fifo_lvl), 32'd4);
        drive(32'hCAFEF00D, 0, 4);
        for (int i = 0; i < 5; i++) tick();
        chk("full_held", 32'(bus.md_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n = 0;
        completed = 0;
        while (!completed && n < 20) begin
            tick();
            n++;
        end
        bus.md_valid = 1'b0;
        chk("full_release_latency", 32'(n), 32'd2);
        chk("full_release_lvl", 32'(fifo_lvl), 32'd4);

        // Illegal transfer still answered while full.
        xfer(32'h0, 2, 3, lat);
        chk("ill_full_latency", 32'(lat), 32'd2);

        // Drain to two, then push and pop on the same edge.
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        drive(32'h01020304, 0, 3);
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        bus.md_valid = 1'b0;
        chk("pushpop_lvl", 32'(fifo_lvl), 32'd2);
        tick();

        // Reset while responding.
        drive(32'h9ABCDEF0, 1, 1);
        tick();
        chk("rst_in_resp", 32'(bus.md_ready), 32'd1);
        reset_n = 1'b0;
        tick();
        bus.md_valid = 1'b0;
        reset_n = 1'b1;
        chk("rst_lvl", 32'(fifo_lvl), 32'd0);
        tick();

        // Random traffic with random consumer back-pressure.
        rand_pop = 1;
        for (int t = 0; t < 300; t++) begin
            xfer($urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), lat);
            n = int'($urandom_range(0, 2));
            for (int k = 0; k < n; k++) tick();
        end
        rand_pop = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("drain_lvl", 32'(fifo_lvl), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
